// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults, x0 constant and channel-slice helper for the write-back stage
package wb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF = 16;
  localparam int REG_X0 = 0;
  function automatic int ch_lo(input int ch, input int w);
    return ch * w;
  endfunction
endpackage

// File: rtl/wb_multi_stage_if.sv
// wb_multi_stage_if: execute-side inputs and register-file write-back outputs; forwarding signals with WB_FWD_EN
interface wb_multi_stage_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = wb_pkg::DATA_W_DEF,
  parameter int REG_AW = wb_pkg::REG_AW_DEF,
  parameter int CNT_W = wb_pkg::CNT_W_DEF
);
  logic stall;
  logic [NUM_CH*REG_AW-1:0] ch_rd_dec;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH*DATA_W-1:0] ch_result;
  logic [NUM_CH*REG_AW-1:0] wb_addr;
  logic [NUM_CH*DATA_W-1:0] wb_data;
  logic [NUM_CH-1:0] wb_en;
  logic [CNT_W-1:0] retire_cnt;
`ifdef WB_FWD_EN
  logic [2*REG_AW-1:0] rs_addr;
  logic [1:0] fwd_hit;
  logic [2*DATA_W-1:0] fwd_data;
  modport master(output stall, ch_rd_dec, ch_valid, ch_result, rs_addr,
                 input wb_addr, wb_data, wb_en, retire_cnt, fwd_hit, fwd_data);
  modport slave(input stall, ch_rd_dec, ch_valid, ch_result, rs_addr,
                output wb_addr, wb_data, wb_en, retire_cnt, fwd_hit, fwd_data);
`else
  modport master(output stall, ch_rd_dec, ch_valid, ch_result,
                 input wb_addr, wb_data, wb_en, retire_cnt);
  modport slave(input stall, ch_rd_dec, ch_valid, ch_result,
                output wb_addr, wb_data, wb_en, retire_cnt);
`endif
endinterface

// File: rtl/wb_rd_delay.sv
// wb_rd_delay: DEPTH-deep destination-register shift pipe with hold and sync active-low clear
module wb_rd_delay #(
  parameter int W = 5,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s [DEPTH];
  always_ff @(posedge clk)
    if (!reset) s <= '{default: '0};
    else if (!hold) begin
      s[0] <= d;
      for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
    end
  assign q = s[DEPTH-1];
endmodule

// File: rtl/wb_multi_stage.sv
// wb_multi_stage: multi-channel write-back with x0 suppression, collision resolution, retire count; forwarding with WB_FWD_EN
module wb_multi_stage import wb_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int RD_DELAY = 2,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic reset,
  wb_multi_stage_if.slave bus
);
  logic [REG_AW-1:0] rd_al [NUM_CH];
  logic [NUM_CH-1:0] acc, en_nxt;
  logic [2:0] n;
  logic [CNT_W:0] sum;
  logic [CNT_W-1:0] cnt_nxt;
  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_pipe
    wb_rd_delay #(.W(REG_AW), .DEPTH(RD_DELAY)) u_rd (
      .clk(clk),
      .reset(reset),
      .hold(bus.stall),
      .d(bus.ch_rd_dec[ch_lo(g, REG_AW) +: REG_AW]),
      .q(rd_al[g])
    );
  end
  // the highest-index channel wins a same-register collision
  always_comb begin
    acc = bus.ch_valid & {NUM_CH{~bus.stall}};
    en_nxt = acc;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + 3'(acc[i]);
      if (rd_al[i] == REG_AW'(REG_X0)) en_nxt[i] = 1'b0;
      for (int k = i + 1; k < NUM_CH; k++)
        if (acc[k] && rd_al[k] == rd_al[i]) en_nxt[i] = 1'b0;
    end
    sum = {1'b0, bus.retire_cnt} + (CNT_W+1)'(n);
    cnt_nxt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end
  always_ff @(posedge clk)
    if (!reset) begin
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
      bus.wb_en <= '0;
      bus.retire_cnt <= '0;
    end else begin
      bus.wb_en <= en_nxt;
      bus.retire_cnt <= cnt_nxt;
      for (int i = 0; i < NUM_CH; i++)
        if (acc[i]) begin
          bus.wb_addr[ch_lo(i, REG_AW) +: REG_AW] <= rd_al[i];
          bus.wb_data[ch_lo(i, DATA_W) +: DATA_W] <= bus.ch_result[ch_lo(i, DATA_W) +: DATA_W];
        end
    end
`ifdef WB_FWD_EN
  always_comb begin
    bus.fwd_hit = '0;
    bus.fwd_data = '0;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NUM_CH; i++)
        if (bus.wb_en[i] && bus.rs_addr[ch_lo(j, REG_AW) +: REG_AW] != REG_AW'(REG_X0) &&
            bus.wb_addr[ch_lo(i, REG_AW) +: REG_AW] == bus.rs_addr[ch_lo(j, REG_AW) +: REG_AW]) begin
          bus.fwd_hit[j] = 1'b1;
          bus.fwd_data[ch_lo(j, DATA_W) +: DATA_W] = bus.wb_data[ch_lo(i, DATA_W) +: DATA_W];
        end
  end
`endif
endmodule

// File: tb/tb_wb_multi_stage.sv
// tb_wb_multi_stage: randomized and directed checks of wb_multi_stage against a queue-based reference model
module tb_wb_multi_stage;
  localparam int NC = 2, DW = 32, AW = 5, RD = 2;
  logic clk = 1'b0, reset = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  wb_multi_stage_if #(.NUM_CH(NC), .DATA_W(DW), .REG_AW(AW), .CNT_W(16)) b1();
  wb_multi_stage_if #(.NUM_CH(NC), .DATA_W(DW), .REG_AW(AW), .CNT_W(4)) b2();
  wb_multi_stage #(.NUM_CH(NC), .DATA_W(DW), .REG_AW(AW), .RD_DELAY(RD), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(b1));
  wb_multi_stage #(.NUM_CH(NC), .DATA_W(DW), .REG_AW(AW), .RD_DELAY(RD), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b2));
  assign b2.stall = b1.stall;
  assign b2.ch_rd_dec = b1.ch_rd_dec;
  assign b2.ch_valid = b1.ch_valid;
  assign b2.ch_result = b1.ch_result;
`ifdef WB_FWD_EN
  assign b2.rs_addr = b1.rs_addr;
`endif
  logic [NC*AW-1:0] hist[$];
  logic [NC*AW-1:0] al, ea;
  logic [NC*DW-1:0] ed;
  logic [NC-1:0] ee;
  int c16, c4, na;
  // rd_al is simply the decode rd seen RD non-stalled edges ago
  always @(posedge clk) begin
    if (!reset) begin
      hist.delete();
      ea = '0; ed = '0; ee = '0; c16 = 0; c4 = 0;
    end else begin
      al = hist.size() >= RD ? hist[RD-1] : '0;
      na = 0;
      for (int i = 0; i < NC; i++) begin
        ee[i] = 1'b0;
        if (b1.ch_valid[i] && !b1.stall) begin
          na++;
          ea[i*AW +: AW] = al[i*AW +: AW];
          ed[i*DW +: DW] = b1.ch_result[i*DW +: DW];
          ee[i] = al[i*AW +: AW] != 0;
          for (int k = i + 1; k < NC; k++)
            if (b1.ch_valid[k] && al[k*AW +: AW] == al[i*AW +: AW]) ee[i] = 1'b0;
        end
      end
      c16 = c16 + na > 65535 ? 65535 : c16 + na;
      c4 = c4 + na > 15 ? 15 : c4 + na;
      if (!b1.stall) begin
        hist.push_front(b1.ch_rd_dec);
        if (hist.size() > RD) void'(hist.pop_back());
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic compare();
`ifdef WB_FWD_EN
    logic [1:0] eh;
    logic [2*DW-1:0] efd;
`endif
    chk("wb_en", 64'(b1.wb_en), 64'(ee));
    chk("wb_addr", 64'(b1.wb_addr), 64'(ea));
    chk("wb_data", 64'(b1.wb_data), 64'(ed));
    chk("retire_cnt", 64'(b1.retire_cnt), 64'(c16));
    chk("retire_cnt4", 64'(b2.retire_cnt), 64'(c4));
`ifdef WB_FWD_EN
    eh = '0;
    efd = '0;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NC; i++)
        if (ee[i] && b1.rs_addr[j*AW +: AW] != 0 && ea[i*AW +: AW] == b1.rs_addr[j*AW +: AW]) begin
          eh[j] = 1'b1;
          efd[j*DW +: DW] = ed[i*DW +: DW];
        end
    chk("fwd_hit", 64'(b1.fwd_hit), 64'(eh));
    chk("fwd_data", 64'(b1.fwd_data), 64'(efd));
`endif
  endtask
  task automatic step(input logic rst_n, input logic st, input logic [NC-1:0] v,
                      input logic [NC*AW-1:0] rd, input logic [NC*DW-1:0] res);
    reset = rst_n;
    b1.stall = st;
    b1.ch_valid = v;
    b1.ch_rd_dec = rd;
    b1.ch_result = res;
    @(negedge clk);
    compare();
  endtask
  initial begin
`ifdef WB_FWD_EN
    b1.rs_addr = '0;
`endif
    for (int t = 0; t < 3; t++) step(1'b0, 1'b0, 2'b11, {5'd3, 5'd4}, {32'h1, 32'h2});
    chk("rst_en", 64'(b1.wb_en), 64'd0);
    chk("rst_addr", 64'(b1.wb_addr), 64'd0);
    chk("rst_data", 64'(b1.wb_data), 64'd0);
    chk("rst_cnt", 64'(b1.retire_cnt), 64'd0);
    step(1'b1, 1'b0, 2'b00, {5'd0, 5'd7}, '0);
    step(1'b1, 1'b0, 2'b00, {5'd0, 5'd1}, '0);
    step(1'b1, 1'b0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'hDEADBEEF});
    chk("basic_addr", 64'(b1.wb_addr[AW-1:0]), 64'd7);
    chk("basic_data", 64'(b1.wb_data[DW-1:0]), 64'hDEADBEEF);
    chk("basic_en", 64'(b1.wb_en), 64'b01);
    chk("basic_cnt", 64'(b1.retire_cnt), 64'd1);
    step(1'b1, 1'b0, 2'b00, {5'd0, 5'd12}, '0);
    for (int t = 0; t < 3; t++) begin
      step(1'b1, 1'b1, 2'b11, {5'd9, 5'd9}, {32'h7, 32'h7});
      chk("stall_en", 64'(b1.wb_en), 64'd0);
    end
    step(1'b1, 1'b0, 2'b00, {5'd0, 5'd0}, '0);
    step(1'b1, 1'b0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h1234});
    chk("stall_addr", 64'(b1.wb_addr[AW-1:0]), 64'd12);
    chk("stall_en_after", 64'(b1.wb_en), 64'b01);
    chk("stall_cnt", 64'(b1.retire_cnt), 64'd2);
    step(1'b1, 1'b0, 2'b00, {5'd3, 5'd0}, '0);
    step(1'b1, 1'b0, 2'b00, {5'd0, 5'd0}, '0);
    step(1'b1, 1'b0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h99});
    chk("x0_en", 64'(b1.wb_en), 64'd0);
    chk("x0_cnt", 64'(b1.retire_cnt), 64'd3);
    step(1'b1, 1'b0, 2'b00, {5'd5, 5'd5}, '0);
    step(1'b1, 1'b0, 2'b00, {5'd0, 5'd0}, '0);
    step(1'b1, 1'b0, 2'b11, {5'd0, 5'd0}, {32'hAA, 32'hBB});
    chk("coll_en", 64'(b1.wb_en), 64'b10);
    chk("coll_addr1", 64'(b1.wb_addr[2*AW-1:AW]), 64'd5);
    chk("coll_cnt", 64'(b1.retire_cnt), 64'd5);
`ifdef WB_FWD_EN
    step(1'b1, 1'b0, 2'b00, {5'd9, 5'd0}, '0);
    step(1'b1, 1'b0, 2'b00, {5'd0, 5'd0}, '0);
    b1.rs_addr = {5'd0, 5'd9};
    step(1'b1, 1'b0, 2'b10, {5'd0, 5'd0}, {32'h55, 32'h0});
    chk("fwd_hit0", 64'(b1.fwd_hit[0]), 64'd1);
    chk("fwd_data0", 64'(b1.fwd_data[DW-1:0]), 64'h55);
    chk("fwd_hit1", 64'(b1.fwd_hit[1]), 64'd0);
`endif
    for (int t = 0; t < 400; t++) begin
`ifdef WB_FWD_EN
      b1.rs_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
`endif
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, 2'($urandom),
           {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))}, {$urandom, $urandom});
    end
    step(1'b0, 1'b0, 2'b00, '0, '0);
    for (int t = 0; t < 20; t++) begin
      step(1'b1, 1'b0, 2'b01, {5'd0, 5'($urandom_range(0, 31))}, {32'h0, $urandom});
      if (t == 13) chk("sat_cnt14", 64'(b2.retire_cnt), 64'd14);
    end
    chk("sat_cnt15", 64'(b2.retire_cnt), 64'd15);
    chk("sat_cnt16", 64'(b1.retire_cnt), 64'd20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
